pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Merges hazard stalls (ID load-use, EX multi-cycle)

---
 rtl/pipeline_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_ctrl_wait_timer.sv | 31 +++
 rtl/pipeline_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - stall codes: thermometer masks over {WB,MEM,EX,ID,IF,PC}. The highest
//     held stage sets the code, and every stage below it is held too.
//   - FSM state encoding (2-bit)
//   - default redirect vector for a memory-wait timeout
//   - ctrl_out_t: the bundle of combinational control outputs
package pipeline_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IMEM = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_DMEM = 6'b011111;

  localparam logic [31:0] ERR_VEC_DEF = 32'h0000_0040;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2,
    ST_DRAIN = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_err;
  } ctrl_out_t;

  // Highest-priority hazard code, excluding the fetch wait. The codes are
  // thermometer masks, so OR-ing one with STALL_IMEM yields the larger code.
  function automatic logic [5:0] hazard_code(input logic dwait, input logic ex,
                                             input logic id);
    if (dwait)   return STALL_DMEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_wait_timer.sv
// ctrl_wait_timer: counts the length of a single memory wait.
//   clk, rst_n : clock, async active-low reset
//   start      : load 1. This is the first wait cycle, which was spent in RUN.
//   clear      : return to 0 (the wait is over)
//   enable     : advance by one (still waiting)
//   expire     : count has reached TIMEOUT-1, which is the last allowed wait cycle
module ctrl_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // The FSM always clears on expiry, so cnt never runs past TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (start)  cnt <= W'(1);
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  assign expire = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
//   clk, rst_n      : clock, async active-low reset
//   stallreq_id/ex  : ID load-use hazard / EX multi-cycle busy (levels)
//   imem_req/ready  : fetch outstanding / fetch data valid
//   dmem_req/ready  : load/store outstanding / access completes
//   excp_valid/pc   : exception committed in MEM (pulse) and handler PC
//   stall[5:0]      : {WB,MEM,EX,ID,IF,PC} hold mask
//   flush, new_pc   : one-cycle pipeline clear and redirect target
//   bus_err         : one-cycle pulse when a memory wait times out
//   perf_*_cnt      : stalled-cycle count (saturating), flush count (wrapping)
// stall/flush/new_pc/bus_err are combinational from the registered state and
// the current inputs. They are forced to 0 while rst_n is low.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          TIMEOUT = 256,
  parameter logic [31:0] ERR_VEC = ERR_VEC_DEF,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             imem_req,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             bus_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt
);

  ctrl_state_e state, nxt;
  ctrl_out_t   o;
  logic        pend_excp;
  logic [31:0] pend_pc;
  logic        set_pend, clr_pend;
  logic        tmr_start, tmr_exp;
  logic        dw, iw;
  logic [5:0]  haz;

  assign dw  = dmem_req & ~dmem_ready;
  assign iw  = imem_req & ~imem_ready;
  assign haz = hazard_code(dw, stallreq_ex, stallreq_id);

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .clear  (nxt == ST_RUN),
    .enable (state != ST_RUN),
    .expire (tmr_exp)
  );

  always_comb begin
    o         = '0;
    nxt       = state;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    tmr_start = 1'b0;
    case (state)
      ST_RUN: begin
        if (excp_valid) begin
          o.flush  = 1'b1;
          o.new_pc = excp_pc;
          // The fetch still in flight belongs to the squashed path.
          if (iw) begin
            nxt       = ST_DRAIN;
            tmr_start = 1'b1;
          end
        end else begin
          o.stall = haz | (iw ? STALL_IMEM : STALL_NONE);
          if (dw) begin
            nxt       = ST_DWAIT;
            tmr_start = 1'b1;
          end else if (iw && !stallreq_ex && !stallreq_id) begin
            nxt       = ST_IWAIT;
            tmr_start = 1'b1;
          end
        end
      end
      ST_DWAIT: begin
        if (!dw) begin
          // Access completes. The oldest exception takes the redirect.
          if (pend_excp) begin
            o.flush  = 1'b1;
            o.new_pc = pend_pc;
          end else if (excp_valid) begin
            o.flush  = 1'b1;
            o.new_pc = excp_pc;
          end
          clr_pend = 1'b1;
          nxt      = ST_RUN;
        end else if (tmr_exp) begin
          o.bus_err = 1'b1;
          o.flush   = 1'b1;
          o.new_pc  = ERR_VEC;
          clr_pend  = 1'b1;
          nxt       = ST_RUN;
        end else begin
          o.stall = STALL_DMEM;
          // MEM is frozen, so the flush is deferred until the access ends.
          if (excp_valid && !pend_excp) set_pend = 1'b1;
        end
      end
      ST_IWAIT: begin
        if (iw && tmr_exp) begin
          o.bus_err = 1'b1;
          o.flush   = 1'b1;
          o.new_pc  = ERR_VEC;
          nxt       = ST_RUN;
        end else if (excp_valid) begin
          o.flush  = 1'b1;
          o.new_pc = excp_pc;
          if (iw) begin
            nxt       = ST_DRAIN;
            tmr_start = 1'b1;
          end else begin
            nxt = ST_RUN;
          end
        end else if (dw) begin
          o.stall   = STALL_DMEM;
          nxt       = ST_DWAIT;
          tmr_start = 1'b1;
        end else if (!iw) begin
          o.stall = haz;
          nxt     = ST_RUN;
        end else begin
          o.stall = haz | STALL_IMEM;
        end
      end
      ST_DRAIN: begin
        if (iw && tmr_exp) begin
          o.bus_err = 1'b1;
          o.flush   = 1'b1;
          o.new_pc  = ERR_VEC;
          nxt       = ST_RUN;
        end else begin
          // PC/IF stay held on the ready cycle too, so the stale fetch data
          // is dropped. The next fetch then uses the redirected PC.
          o.stall = haz | STALL_IMEM;
          if (excp_valid) begin
            o.flush  = 1'b1;
            o.new_pc = excp_pc;
          end
          if (!iw) nxt = ST_RUN;
        end
      end
      default: nxt = ST_RUN;
    endcase
    if (!rst_n) o = '0;
  end

  assign stall   = o.stall;
  assign flush   = o.flush;
  assign new_pc  = o.new_pc;
  assign bus_err = o.bus_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      pend_excp      <= 1'b0;
      pend_pc        <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      state <= nxt;
      if (clr_pend) begin
        pend_excp <= 1'b0;
      end else if (set_pend) begin
        pend_excp <= 1'b1;
        pend_pc   <= excp_pc;
      end
      if (o.stall != STALL_NONE && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (o.flush)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end

endmodule
